// File: rtl/pe_array_sequencer_pkg.sv
// Shared types and constants for the PE array sequencer: state encoding,
// default geometry, and the filter-load / drain counter sizing.
package pe_array_sequencer_pkg;

   localparam int unsigned DEF_N_PE   = 8;
   localparam int unsigned DEF_ROW_W  = 8;
   localparam int unsigned DEF_K      = 3;
   localparam int unsigned DEF_PE_LAT = 2;

   // Shared counter for filter-word loading and drain cycles
   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LBRST,
      ST_FILT,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Words per filter: one K x K kernel
   function automatic int unsigned filt_words(input int unsigned k);
      return k * k;
   endfunction

   // Drain counter terminal value; a zero latency still spends one cycle in DRAIN
   function automatic int unsigned drain_last(input int unsigned lat);
      return (lat == 0) ? 0 : lat - 1;
   endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Layer control and pixel/filter handshake between the host side and the sequencer.
interface pe_array_sequencer_if
   import pe_array_sequencer_pkg::*;
#(
   parameter int unsigned N_PE  = DEF_N_PE,
   parameter int unsigned ROW_W = DEF_ROW_W
) ();

   logic             start;
   logic [ROW_W-1:0] row_length;
   logic [ROW_W-1:0] num_rows;
   logic [N_PE-1:0]  pe_mask;
   logic             nl_cfg;
   logic             fb_cfg;
   logic             in_valid;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             cfg_err;

   modport master (
      output start, row_length, num_rows, pe_mask, nl_cfg, fb_cfg, in_valid,
      input  in_ready, busy, done, cfg_err
   );

   modport slave (
      input  start, row_length, num_rows, pe_mask, nl_cfg, fb_cfg, in_valid,
      output in_ready, busy, done, cfg_err
   );

endinterface

// File: rtl/seq_delay_pipe.sv
// W-bit wide, DEPTH-stage shift register used to stagger the per-PE strobes.
module seq_delay_pipe #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pe_array_sequencer.sv
// Layer sequencer for a PE array: loads a K x K filter, streams a frame of
// pixels, and generates the per-PE shift / MAC / adder / NL / feedback strobes.
module pe_array_sequencer
   import pe_array_sequencer_pkg::*;
#(
   parameter int unsigned N_PE   = DEF_N_PE,
   parameter int unsigned ROW_W  = DEF_ROW_W,
   parameter int unsigned K      = DEF_K,
   parameter int unsigned PE_LAT = DEF_PE_LAT
) (
   input  logic                clk,
   input  logic                rst,
   pe_array_sequencer_if.slave bus,
   output logic                line_buffer_reset,
   output logic [N_PE-1:0]     shifting_filter,
   output logic [N_PE-1:0]     shifting_line,
   output logic [N_PE-1:0]     mac_enable,
   output logic [N_PE-1:0]     adder_enable,
   output logic [N_PE-1:0]     nl_enable,
   output logic [N_PE-1:0]     feedback_enable
);

   localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(filt_words(K) - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_last(PE_LAT));
   localparam logic [ROW_W-1:0] K_MIN      = ROW_W'(K);
   localparam logic [ROW_W-1:0] K_EDGE     = ROW_W'(K - 1);

   state_e           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [ROW_W-1:0] col, col_n;
   logic [ROW_W-1:0] row, row_n;

   logic [ROW_W-1:0] rl_q, nr_q;
   logic [N_PE-1:0]  mask_q;
   logic             nl_q, fb_q;

   logic             beat;
   logic             cfg_load, cfg_bad, mac_hit;
   logic [N_PE-1:0]  nl_gate;

   assign beat = bus.in_valid & bus.in_ready;

   // Next-state and counter update
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      col_n    = col;
      row_n    = row;
      cfg_load = 1'b0;
      cfg_bad  = 1'b0;
      mac_hit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               cfg_load = 1'b1;
               if ((bus.row_length < K_MIN) || (bus.num_rows < K_MIN) || (bus.pe_mask == '0))
                  cfg_bad = 1'b1;
               else
                  state_n = ST_LBRST;
            end
         end
         ST_LBRST: begin
            cnt_n   = '0;
            state_n = ST_FILT;
         end
         ST_FILT: begin
            if (beat) begin
               if (cnt == FILT_LAST) begin
                  cnt_n   = '0;
                  col_n   = '0;
                  row_n   = '0;
                  state_n = ST_STREAM;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         ST_STREAM: begin
            if (beat) begin
               mac_hit = (col >= K_EDGE) && (row >= K_EDGE);
               if (col == rl_q - ROW_W'(1)) begin
                  col_n = '0;
                  if (row == nr_q - ROW_W'(1)) begin
                     cnt_n   = '0;
                     state_n = ST_DRAIN;
                  end else begin
                     row_n = row + ROW_W'(1);
                  end
               end else begin
                  col_n = col + ROW_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (cnt == DRAIN_LAST) state_n = ST_DONE;
            else                   cnt_n   = cnt + CNT_W'(1);
         end
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // State, counters, latched config and registered control outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= ST_IDLE;
         cnt               <= '0;
         col               <= '0;
         row               <= '0;
         rl_q              <= '0;
         nr_q              <= '0;
         mask_q            <= '0;
         nl_q              <= 1'b0;
         fb_q              <= 1'b0;
         bus.in_ready      <= 1'b0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
         bus.cfg_err       <= 1'b0;
         line_buffer_reset <= 1'b0;
         mac_enable        <= '0;
         feedback_enable   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         col   <= col_n;
         row   <= row_n;
         if (cfg_load) begin
            rl_q   <= bus.row_length;
            nr_q   <= bus.num_rows;
            mask_q <= bus.pe_mask;
            nl_q   <= bus.nl_cfg;
            fb_q   <= bus.fb_cfg;
         end
         bus.in_ready      <= (state_n == ST_FILT) || (state_n == ST_STREAM);
         bus.busy          <= (state_n != ST_IDLE);
         bus.done          <= (state_n == ST_DONE);
         bus.cfg_err       <= cfg_bad;
         line_buffer_reset <= (state_n == ST_LBRST);
         mac_enable        <= mac_hit ? mask_q : '0;
         feedback_enable   <= (fb_q && ((state_n == ST_STREAM) || (state_n == ST_DRAIN))) ? mask_q : '0;
      end
   end

   // Shift strobes track the accepting beat in the same cycle
   assign shifting_filter = ((state == ST_FILT)   && beat) ? mask_q : '0;
   assign shifting_line   = ((state == ST_STREAM) && beat) ? mask_q : '0;

   assign nl_gate = adder_enable & {N_PE{nl_q}};

   seq_delay_pipe #(.W(N_PE), .DEPTH(1)) u_adder_pipe (
      .clk  (clk),
      .rst  (rst),
      .din  (mac_enable),
      .dout (adder_enable)
   );

   seq_delay_pipe #(.W(N_PE), .DEPTH(1)) u_nl_pipe (
      .clk  (clk),
      .rst  (rst),
      .din  (nl_gate),
      .dout (nl_enable)
   );

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: each layer pushes its expected
// strobe tallies; a monitor tallies the DUT strobes and checks on done/cfg_err.
module tb_pe_array_sequencer;

   localparam int unsigned N_PE  = 8;
   localparam int unsigned ROW_W = 8;

   typedef struct {
      bit         err;
      int         lbr, filt, line, mac, add, nl, fb;
      logic [7:0] mask, nl_or, fb_or;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic            line_buffer_reset;
   logic [N_PE-1:0] shifting_filter, shifting_line, mac_enable;
   logic [N_PE-1:0] adder_enable, nl_enable, feedback_enable;

   pe_array_sequencer_if #(.N_PE(N_PE), .ROW_W(ROW_W)) bus ();

   pe_array_sequencer #(.N_PE(N_PE), .ROW_W(ROW_W), .K(3), .PE_LAT(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus),
      .line_buffer_reset (line_buffer_reset),
      .shifting_filter   (shifting_filter),
      .shifting_line     (shifting_line),
      .mac_enable        (mac_enable),
      .adder_enable      (adder_enable),
      .nl_enable         (nl_enable),
      .feedback_enable   (feedback_enable)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;
   exp_t sb_q[$];

   int a_lbr, a_filt, a_line, a_mac, a_add, a_nl, a_fb;
   logic [7:0] a_sf_or, a_sl_or, a_mac_or, a_add_or, a_nl_or, a_fb_or;
   int cyc = 0, last_mac = 0, events = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_acc();
      a_lbr = 0; a_filt = 0; a_line = 0; a_mac = 0; a_add = 0; a_nl = 0; a_fb = 0;
      a_sf_or = '0; a_sl_or = '0; a_mac_or = '0; a_add_or = '0; a_nl_or = '0; a_fb_or = '0;
   endtask

   // Monitor: tally strobes, check against the scoreboard on each layer event
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         clear_acc();
      end else begin
         a_lbr += int'(line_buffer_reset);
         if (shifting_filter != '0) begin a_filt++; a_sf_or  |= shifting_filter; end
         if (shifting_line   != '0) begin a_line++; a_sl_or  |= shifting_line;   end
         if (mac_enable      != '0) begin a_mac++;  a_mac_or |= mac_enable; last_mac = cyc; end
         if (adder_enable    != '0) begin a_add++;  a_add_or |= adder_enable;    end
         if (nl_enable       != '0) begin a_nl++;   a_nl_or  |= nl_enable;       end
         if (feedback_enable != '0) begin a_fb++;   a_fb_or  |= feedback_enable; end
         if (bus.done || bus.cfg_err) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_event", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("cfg_err",      int'(bus.cfg_err), int'(e.err));
               chk("done",         int'(bus.done), int'(!e.err));
               chk("busy",         int'(bus.busy), int'(!e.err));
               chk("lbr_count",    a_lbr,  e.lbr);
               chk("filt_count",   a_filt, e.filt);
               chk("line_count",   a_line, e.line);
               chk("mac_count",    a_mac,  e.mac);
               chk("adder_count",  a_add,  e.add);
               chk("nl_count",     a_nl,   e.nl);
               chk("fb_count",     a_fb,   e.fb);
               chk("filt_mask",    int'(a_sf_or),  int'(e.mask));
               chk("line_mask",    int'(a_sl_or),  int'(e.mask));
               chk("mac_mask",     int'(a_mac_or), int'(e.mask));
               chk("adder_mask",   int'(a_add_or), int'(e.mask));
               chk("nl_mask",      int'(a_nl_or),  int'(e.nl_or));
               chk("fb_mask",      int'(a_fb_or),  int'(e.fb_or));
               if (!e.err && e.mac > 0) chk("done_after_mac", cyc - last_mac, 2);
            end
            clear_acc();
            events++;
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, int'({bus.in_ready, bus.busy, bus.done, bus.cfg_err, line_buffer_reset}), 0);
      chk({tag, "_pe"}, int'({shifting_filter, shifting_line, mac_enable, adder_enable,
                              nl_enable, feedback_enable} != '0), 0);
   endtask

   // One layer: start with cfg, then junk the config inputs while streaming
   task automatic run_layer(input logic [7:0] rl, input logic [7:0] nr, input logic [7:0] mask,
                            input logic nl, input logic fb, input bit toggle,
                            input int start_at, input int rst_at, input bit push, input exp_t e);
      int  ev0;
      bit  aborted;
      aborted = 0;
      if (push) sb_q.push_back(e);
      ev0 = events;
      bus.row_length = rl; bus.num_rows = nr; bus.pe_mask = mask;
      bus.nl_cfg = nl; bus.fb_cfg = fb; bus.in_valid = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.row_length = 8'd2; bus.num_rows = 8'd2; bus.pe_mask = 8'h00;
      bus.nl_cfg = ~nl; bus.fb_cfg = ~fb;
      for (int c = 0; c < 400 && events == ev0 && !aborted; c++) begin
         bus.in_valid = toggle ? ~bus.in_valid : 1'b1;
         bus.start = (start_at >= 0 && a_line == start_at);
         if (rst_at >= 0 && a_line == rst_at) begin
            rst = 1'b0;
            @(posedge clk); #1;
            chk_zero("abort");
            rst = 1'b1;
            aborted = 1;
         end
         @(posedge clk); #1;
      end
      if (!aborted && events == ev0) chk("layer_timeout", 0, 1);
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input bit err, input int line, input int mac, input int nl,
                               input int fb, input logic [7:0] mask, input logic [7:0] nl_or,
                               input logic [7:0] fb_or);
      exp_t e;
      e.err = err; e.lbr = err ? 0 : 1; e.filt = err ? 0 : 9; e.line = line;
      e.mac = mac; e.add = mac; e.nl = nl; e.fb = fb;
      e.mask = mask; e.nl_or = nl_or; e.fb_or = fb_or;
      return e;
   endfunction

   initial begin
      exp_t none;
      none = mk(1'b1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.row_length = '0; bus.num_rows = '0;
      bus.pe_mask = '0; bus.nl_cfg = 1'b0; bus.fb_cfg = 1'b0;
      clear_acc();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // 5x5, all PEs, continuous valid
      run_layer(8'd5, 8'd5, 8'hFF, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1,
                mk(1'b0, 25, 9, 9, 0, 8'hFF, 8'hFF, 8'h00));
      // Same layer with in_valid toggling every cycle
      run_layer(8'd5, 8'd5, 8'hFF, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1,
                mk(1'b0, 25, 9, 9, 0, 8'hFF, 8'hFF, 8'h00));
      // Illegal configurations
      run_layer(8'd2, 8'd5, 8'hFF, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, none);
      run_layer(8'd5, 8'd2, 8'hFF, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, none);
      run_layer(8'd5, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, none);
      // Start pulse mid-stream is ignored; feedback spans STREAM+DRAIN (25+2)
      run_layer(8'd5, 8'd5, 8'hFF, 1'b1, 1'b1, 1'b0, 10, -1, 1'b1,
                mk(1'b0, 25, 9, 9, 27, 8'hFF, 8'hFF, 8'hFF));
      // Reset at pixel 12 aborts silently, then a full layer runs
      run_layer(8'd5, 8'd5, 8'hFF, 1'b1, 1'b0, 1'b0, -1, 12, 1'b0, none);
      run_layer(8'd5, 8'd5, 8'hFF, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1,
                mk(1'b0, 25, 9, 9, 0, 8'hFF, 8'hFF, 8'h00));
      // NL off, feedback on, lower four PEs only
      run_layer(8'd5, 8'd5, 8'h0F, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1,
                mk(1'b0, 25, 9, 0, 27, 8'h0F, 8'h00, 8'h0F));
      // Non-square 6x4: (6-2)*(4-2)=8 MACs, feedback 24+2 cycles
      run_layer(8'd6, 8'd4, 8'hA5, 1'b1, 1'b1, 1'b0, -1, -1, 1'b1,
                mk(1'b0, 24, 8, 8, 26, 8'hA5, 8'hA5, 8'hA5));
      // Minimum legal frame 3x3: a single MAC
      run_layer(8'd3, 8'd3, 8'h01, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1,
                mk(1'b0, 9, 1, 1, 0, 8'h01, 8'h01, 8'h00));

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
